calf_inject_ctrl: RTL

//  Injection scheduler for the local port (port 4) of the CALF bufferless router (brouter).

---
 rtl/calf_inject_ctrl_pkg.sv | 12 +
 rtl/calf_inj_fifo.sv | 50 +++++
 rtl/calf_inject_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/calf_inject_ctrl_pkg.sv
// rtl/calf_inject_ctrl_pkg.sv - shared widths, flit valid bit and injection FSM encodings
package calf_inject_ctrl_pkg;

   localparam int CONTROL_W      = 144;
   localparam int FLIT_VALID_BIT = CONTROL_W - 1;

   typedef enum logic {
      INJ_IDLE  = 1'b0,
      INJ_OFFER = 1'b1
   } inj_state_t;

endpackage

// File: rtl/calf_inj_fifo.sv
// rtl/calf_inj_fifo.sv - DEPTH x FLIT_W register FIFO with occupancy count
module calf_inj_fifo #(
   parameter int FLIT_W = 144,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [FLIT_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [FLIT_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/calf_inject_ctrl.sv
// rtl/calf_inject_ctrl.sv - local-port injection scheduler; CALF_INJ_STARVE_EN enables starvation tracking
module calf_inject_ctrl
   import calf_inject_ctrl_pkg::*;
#(
   parameter int FLIT_W       = CONTROL_W,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     src_valid,
   input  logic [FLIT_W-1:0]        src_flit,
   output logic                     src_ready,
   output logic [FLIT_W-1:0]        port4_ci,
   input  logic                     port4_ready,
   input  logic                     port4_ack,
   output logic [$clog2(DEPTH):0]   inj_count,
   output logic                     starved
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   inj_state_t        state_q;
   inj_state_t        state_d;
   logic              push;
   logic              pop;
   logic              offer;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] head;

   // Ready comes only from registered occupancy, so ack never opens a same-cycle push.
   assign src_ready = !fifo_full;
   assign push      = src_valid && !fifo_full;
   assign pop       = offer && port4_ack;

   calf_inj_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (src_flit),
      .rd_en   (pop),
      .rd_data (head),
      .count   (inj_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= INJ_IDLE;
      else     state_q <= state_d;
   end

   // Next state and offer mux; a flit pushed while idle is not bypassed.
   always_comb begin
      state_d  = state_q;
      offer    = 1'b0;
      port4_ci = '0;
      case (state_q)
         INJ_IDLE: begin
            if (push) state_d = INJ_OFFER;
         end
         INJ_OFFER: begin
            offer = port4_ready && !fifo_empty;
            if (offer) port4_ci = head;
            if (offer && port4_ack && inj_count == CNT_W'(1) && !push) state_d = INJ_IDLE;
         end
         default: state_d = INJ_IDLE;
      endcase
   end

`ifdef CALF_INJ_STARVE_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

   logic [SC_W-1:0] starve_cnt;

   // Saturating count of consecutive blocked offer cycles; any pop or idle clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state_q == INJ_IDLE || pop) begin
         starve_cnt <= '0;
      end else if (!port4_ready && starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   assign starved = (starve_cnt == LIMIT);
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;
   assign starved = 1'b0;
`endif

endmodule
